// File: rtl/haar_dwt_line_engine.sv
// haar_dwt_line_engine
//   Streaming 1-D integer Haar (lifting) engine. Forward mode turns each line
//   of LINE_LEN pixels into LINE_LEN/2 low-pass (s) coefficients followed by
//   LINE_LEN/2 high-pass (d) coefficients. Inverse mode consumes that subband
//   order and rebuilds the pixel line. Direction is chosen per frame at start.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   start, mode          frame start pulse (accepted in IDLE); 0=forward 1=inverse
//   in_valid/in_ready    input handshake, in_data = signed sample/coefficient
//   out_valid/out_ready  output handshake, out_data = signed result
//   out_last             final output beat of each line
//   busy                 frame in progress
//   frame_done           sticky end-of-frame flag, cleared by the next start
//
// State table
//   IDLE      | waiting for start
//   F_EVEN    | forward: take even sample a
//   F_ODD     | forward: take odd sample b, emit s, store d
//   F_DRAIN   | forward: emit stored d coefficients, last one flagged
//   I_LOAD    | inverse: store the line's s coefficients
//   I_H       | inverse: take d, emit a, hold b
//   I_ODD_OUT | inverse: emit held b once a has been accepted
//   DONE      | frame finished, one cycle before IDLE

module haar_dwt_line_engine #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 512,
  parameter int NUM_LINES = 512
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int C_W    = DATA_W + 1;
  localparam int HALF   = LINE_LEN / 2;
  localparam int IDX_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(HALF - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    F_EVEN,
    F_ODD,
    F_DRAIN,
    I_LOAD,
    I_H,
    I_ODD_OUT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [C_W-1:0]    a_q, a_d;
  logic [C_W-1:0]    b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [C_W-1:0]    out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  // Half-line buffer: forward holds d coefficients, inverse holds s.
  logic [C_W-1:0]    mem [HALF];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [C_W-1:0]    mem_wd;
  logic [IDX_W-1:0]  mem_ra;
  logic [C_W-1:0]    rd_data_q;

  logic              consuming;
  logic              out_free;
  logic              out_fire;
  logic              in_fire;
  logic              last_held;

  // Lifting arithmetic. The results are kept to C_W bits, which wraps exactly
  // like a C_W+1 wide datapath truncated at the end. Only the difference needs
  // the extra bit, because floor(d/2) is its top C_W bits.
  logic [C_W:0]      fwd_diff;
  logic [C_W-1:0]    fwd_sum;
  logic [C_W-1:0]    inv_half;
  logic [C_W-1:0]    inv_a;
  logic [C_W-1:0]    inv_b;

  assign fwd_diff = {in_data[C_W-1], in_data} - {a_q[C_W-1], a_q};
  assign fwd_sum  = a_q + fwd_diff[C_W:1];
  assign inv_half = {in_data[C_W-1], in_data[C_W-1:1]};
  assign inv_a    = rd_data_q - inv_half;
  assign inv_b    = in_data + inv_a;

  assign consuming = (state_q == F_EVEN) || (state_q == F_ODD) ||
                     (state_q == I_LOAD) || (state_q == I_H);
  assign out_free  = !out_valid_q || out_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign in_ready  = consuming && out_free;
  assign in_fire   = in_valid && in_ready;
  // The flagged final beat of a line is loaded and waiting for acceptance.
  assign last_held = out_valid_q && out_last_q;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    k_d          = k_q;
    line_d       = line_q;
    a_d          = a_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    mem_we       = 1'b0;
    mem_wa       = k_q;
    mem_wd       = in_data;
    // Keeping the read address on k leaves buffer[k] waiting in rd_data_q.
    mem_ra       = k_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d       = mode;
          busy_d       = 1'b1;
          frame_done_d = 1'b0;
          k_d          = '0;
          line_d       = '0;
          state_d      = mode ? I_LOAD : F_EVEN;
        end
      end

      F_EVEN: begin
        if (in_fire) begin
          a_d     = in_data;
          state_d = F_ODD;
        end
      end

      F_ODD: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = fwd_sum;
          out_last_d  = 1'b0;
          mem_we      = 1'b1;
          mem_wd      = fwd_diff[C_W-1:0];
          if (k_q == K_LAST) begin
            // Prefetch buffer[0] so the first H beat can follow the last L beat.
            k_d     = '0;
            mem_ra  = '0;
            state_d = F_DRAIN;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = F_EVEN;
          end
        end
      end

      F_DRAIN: begin
        if (!last_held && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data_q;
          if (k_q == K_LAST) begin
            out_last_d = 1'b1;
          end else begin
            out_last_d = 1'b0;
            k_d        = k_q + IDX_W'(1);
            mem_ra     = k_q + IDX_W'(1);
          end
        end
      end

      I_LOAD: begin
        if (in_fire) begin
          mem_we = 1'b1;
          mem_wd = in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            mem_ra  = '0;
            state_d = I_H;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end

      I_H: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = inv_a;
          out_last_d  = 1'b0;
          b_d         = inv_b;
          state_d     = I_ODD_OUT;
        end
      end

      I_ODD_OUT: begin
        // Fetch s for the next pair while b is pending.
        mem_ra = k_q + IDX_W'(1);
        if (!last_held && out_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = b_q;
          if (k_q == K_LAST) begin
            out_last_d = 1'b1;
          end else begin
            out_last_d = 1'b0;
            k_d        = k_q + IDX_W'(1);
            state_d    = I_H;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Line end: the flagged beat leaves the output register.
    if (out_fire && out_last_q) begin
      out_last_d = 1'b0;
      k_d        = '0;
      if (line_q != LINE_LAST) begin
        line_d  = line_q + LINE_W'(1);
        state_d = mode_q ? I_LOAD : F_EVEN;
      end else begin
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = DONE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      k_q          <= '0;
      line_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      k_q          <= k_d;
      line_q       <= line_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    rd_data_q <= mem[mem_ra];
  end

endmodule

// File: tb/tb_haar_dwt_line_engine.sv
module tb_haar_dwt_line_engine;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = 9'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic       out_last;
  logic       busy;
  logic       frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  int         stim_i [8];
  int         exp_i  [8];
  logic [8:0] got_d  [8];
  logic       got_l  [8];
  int         n_got, stall_err, first_out_in, extra_beats;
  logic       early_done, timed_out, fd_after_start, busy_seen;
  logic       done_after, busy_after;

  haar_dwt_line_engine #(.DATA_W(8), .LINE_LEN(4), .NUM_LINES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  // Drives one two-line frame; inputs change on the falling edge and the
  // handshakes are sampled 4 ns later, just before the rising edge.
  task automatic run_frame(input logic m, input int pin, input int pout, input int inj);
    int n_in;
    int cyc;
    logic pend;
    logic [8:0] pd;
    logic pl;
    n_in = 0; n_got = 0; stall_err = 0; first_out_in = -1; extra_beats = 0;
    early_done = 0; pend = 0; pd = 0; pl = 0; fd_after_start = 1; busy_seen = 0;
    @(negedge HCLK); start = 1; mode = m;
    @(negedge HCLK); start = 0;
    cyc = 0;
    while (n_got < 8 && cyc < 2000) begin
      start = (cyc == inj);
      mode = (cyc == inj) ? ~m : m;
      in_valid = (n_in < 8) && ($urandom_range(99) < pin);
      in_data = (n_in < 8) ? 9'(stim_i[n_in]) : 9'd0;
      out_ready = ($urandom_range(99) < pout);
      #4;
      if (cyc == 0) begin fd_after_start = frame_done; busy_seen = busy; end
      if (pend && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (frame_done) early_done = 1;
      if (out_valid && first_out_in < 0) first_out_in = n_in;
      if (out_valid && out_ready) begin
        got_d[n_got] = out_data; got_l[n_got] = out_last; n_got++;
      end
      pend = out_valid && !out_ready; pd = out_data; pl = out_last;
      if (in_valid && in_ready) n_in++;
      @(negedge HCLK);
      cyc++;
    end
    start = 0; mode = m; in_valid = 0; out_ready = 1;
    repeat (4) begin
      #4;
      if (out_valid) extra_beats++;
      @(negedge HCLK);
    end
    #4;
    done_after = frame_done; busy_after = busy;
    timed_out = (n_got < 8);
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 0;
    repeat (3) @(negedge HCLK);
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_data, out_last, busy, frame_done} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d last=%b busy=%b done=%b required all 0",
               in_ready, out_valid, out_data, out_last, busy, frame_done);
    end
    @(negedge HCLK); HRESETn = 1;
    @(negedge HCLK); #4;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b vld=%b required 0 0", busy, out_valid);
    end
    @(negedge HCLK);
  endtask

  task automatic test_forward();
    stim_i = '{10, 20, 30, 25, 0, 255, 255, 0};
    exp_i  = '{15, 27, 10, -5, 127, 127, 255, -255};
    run_frame(1'b0, 100, 100, -1);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL fwd_timeout: got %0d beats required 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_d[i] !== 9'(exp_i[i])) begin
        tests_failed++;
        $display("FAIL fwd_data[%0d]: got %0d required %0d", i, $signed(got_d[i]), exp_i[i]);
      end
      tests_run++;
      if (got_l[i] !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL fwd_last[%0d]: got %b required %b", i, got_l[i], (i == 3 || i == 7));
      end
    end
    tests_run++;
    if (first_out_in !== 2) begin tests_failed++; $display("FAIL fwd_first_out: got after %0d inputs required 2", first_out_in); end
    tests_run++;
    if (busy_seen !== 1'b1) begin tests_failed++; $display("FAIL fwd_busy: got %b required 1", busy_seen); end
    tests_run++;
    if (done_after !== 1'b1 || busy_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_end: got done=%b busy=%b required 1 0", done_after, busy_after);
    end
    tests_run++;
    if (extra_beats !== 0) begin tests_failed++; $display("FAIL fwd_extra: got %0d beats required 0", extra_beats); end
  endtask

  task automatic test_inverse();
    stim_i = '{15, 27, 10, -5, 127, 127, 255, -255};
    exp_i  = '{10, 20, 30, 25, 0, 255, 255, 0};
    run_frame(1'b1, 100, 100, -1);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL inv_timeout: got %0d beats required 8", n_got); end
    tests_run++;
    if (fd_after_start !== 1'b0) begin tests_failed++; $display("FAIL inv_done_clear: got %b required 0", fd_after_start); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_d[i] !== 9'(exp_i[i])) begin
        tests_failed++;
        $display("FAIL inv_data[%0d]: got %0d required %0d", i, $signed(got_d[i]), exp_i[i]);
      end
      tests_run++;
      if (got_l[i] !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL inv_last[%0d]: got %b required %b", i, got_l[i], (i == 3 || i == 7));
      end
    end
    tests_run++;
    if (first_out_in !== 3) begin tests_failed++; $display("FAIL inv_first_out: got after %0d inputs required 3", first_out_in); end
    tests_run++;
    if (done_after !== 1'b1 || busy_after !== 1'b0 || extra_beats !== 0) begin
      tests_failed++;
      $display("FAIL inv_end: got done=%b busy=%b extra=%0d required 1 0 0", done_after, busy_after, extra_beats);
    end
  endtask

  task automatic test_backpressure();
    stim_i = '{3, 7, 100, 50, 200, 1, 9, 9};
    exp_i  = '{5, 75, 4, -50, 100, 9, -199, 0};
    run_frame(1'b0, 50, 50, -1);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL bp_timeout: got %0d beats required 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_d[i] !== 9'(exp_i[i]) || got_l[i] !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL bp_beat[%0d]: got %0d last=%b required %0d last=%b", i, $signed(got_d[i]), got_l[i],
                 exp_i[i], (i == 3 || i == 7));
      end
    end
    tests_run++;
    if (stall_err !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_err); end
    tests_run++;
    if (early_done !== 1'b0) begin tests_failed++; $display("FAIL bp_early_done: got %b required 0", early_done); end
    tests_run++;
    if (done_after !== 1'b1 || extra_beats !== 0) begin
      tests_failed++;
      $display("FAIL bp_end: got done=%b extra=%0d required 1 0", done_after, extra_beats);
    end
  endtask

  task automatic test_start_while_busy();
    stim_i = '{10, 20, 30, 25, 0, 255, 255, 0};
    exp_i  = '{15, 27, 10, -5, 127, 127, 255, -255};
    run_frame(1'b0, 100, 70, 6);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL swb_timeout: got %0d beats required 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_d[i] !== 9'(exp_i[i])) begin
        tests_failed++;
        $display("FAIL swb_data[%0d]: got %0d required %0d", i, $signed(got_d[i]), exp_i[i]);
      end
    end
    tests_run++;
    if (done_after !== 1'b1 || busy_after !== 1'b0 || extra_beats !== 0) begin
      tests_failed++;
      $display("FAIL swb_end: got done=%b busy=%b extra=%0d required 1 0 0", done_after, busy_after, extra_beats);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    int stale;
    stim_i = '{10, 20, 30, 25, 0, 255, 255, 0};
    @(negedge HCLK); start = 1; mode = 0;
    @(negedge HCLK); start = 0;
    n = 0; cyc = 0; out_ready = 1;
    while (n < 3 && cyc < 50) begin
      in_valid = 1; in_data = 9'(stim_i[n]);
      #4;
      if (in_ready) n++;
      @(negedge HCLK);
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    #4;
    tests_run++;
    if (n !== 3 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got inputs=%0d busy=%b required 3 1", n, busy);
    end
    @(negedge HCLK); HRESETn = 0;
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_data, out_last, busy, frame_done} !== 14'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got rdy=%b vld=%b data=%0d last=%b busy=%b done=%b required all 0",
               in_ready, out_valid, out_data, out_last, busy, frame_done);
    end
    repeat (2) @(negedge HCLK);
    HRESETn = 1; out_ready = 1;
    stale = 0;
    repeat (5) begin
      #4;
      if (out_valid || busy) stale++;
      @(negedge HCLK);
    end
    tests_run++;
    if (stale !== 0) begin tests_failed++; $display("FAIL rst_mid_stale: got %0d active cycles required 0", stale); end
    stim_i = '{127, 127, 255, -255, 15, 27, 10, -5};
    exp_i  = '{0, 255, 255, 0, 10, 20, 30, 25};
    run_frame(1'b1, 100, 100, -1);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL rst_inv_timeout: got %0d beats required 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_d[i] !== 9'(exp_i[i]) || got_l[i] !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL rst_inv_beat[%0d]: got %0d last=%b required %0d last=%b", i, $signed(got_d[i]), got_l[i],
                 exp_i[i], (i == 3 || i == 7));
      end
    end
    tests_run++;
    if (extra_beats !== 0 || done_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_inv_end: got extra=%0d done=%b required 0 1", extra_beats, done_after);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/haar_dwt_line_engine.md
Name: haar_dwt_line_engine

Overview:
Parametrised streaming 1-D integer Haar (lifting) engine for the image-processing pipeline, the successor to the fixed single-image DWT top-level. It handles both forward (DWT) and inverse (IDWT) transforms, selected per frame, with configurable sample width, line length and line count. Forward mode emits each line in subband order (all L, then all H). Inverse mode consumes that order and reconstructs pixels. A sticky frame-done flag replaces the top-level Write_Done.

Parameters:
DATA_W, 8, pixel width; coefficients are signed C_W = DATA_W+1 bits.
LINE_LEN, 512, samples per line; even, >= 4.
NUM_LINES, 512, lines per frame; >= 1.

Ports:
HCLK  in  1  clock; all logic on rising edge.
HRESETn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a frame when idle.
mode  in  1  sampled with start: 0 = forward, 1 = inverse.
in_valid  in  1  input beat valid.
in_ready  out  1  engine accepts the beat this cycle.
in_data  in  C_W  signed sample/coefficient.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  C_W  signed result.
out_last  out  1  marks the final output beat of each line.
busy  out  1  frame in progress.
frame_done  out  1  sticky; set at end of frame, cleared by next accepted start.

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_data, out_last, busy and frame_done = 0; counters = 0. Buffer contents are don't-care.
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready. Once out_valid is high, out_data and out_last hold until accepted. No combinational path from out_ready or in_valid to out_valid or out_data.
- Single registered output stage. in_ready = 1 only in an input-consuming state when the output register is empty or is being accepted this cycle.
- start is accepted only in IDLE. It latches mode, sets busy, and clears frame_done. start while busy is ignored.
- Arithmetic: internal width C_W+1. floor(x/2) is an arithmetic shift right. Results are truncated to C_W bits (wrap; no saturation).
- Forward: d = b - a; s = a + floor(d/2), with a = even sample and b = odd sample.
- Inverse: a = s - floor(d/2); b = d + a.
- Half-line buffer: LINE_LEN/2 x C_W, synchronous read.
- States: IDLE, F_EVEN, F_ODD, F_DRAIN, I_LOAD, I_H, I_ODD_OUT, DONE.
- F_EVEN: accept sample, hold as a, go to F_ODD.
- F_ODD: accept b. s_k goes into the output register (valid next cycle). d_k is written to buffer[k]. If k = LINE_LEN/2-1, go to F_DRAIN; else go to F_EVEN.
- F_DRAIN: in_ready = 0. Emit buffer[0..LINE_LEN/2-1] in order; out_last on the final beat. The first H beat is valid no later than 2 cycles after the last L beat is accepted.
- I_LOAD: accept LINE_LEN/2 L coefficients into the buffer; no output. Then go to I_H.
- I_H: accept d_k and read s_k. a goes into the output register; b is held. Go to I_ODD_OUT.
- I_ODD_OUT: in_ready = 0. After a is accepted, load b into the output register; out_last is set on b when k = LINE_LEN/2-1. Then return to I_H, or to the line end.
- Line end: occurs when the out_last beat is accepted. If line count < NUM_LINES-1, increment and go to F_EVEN / I_LOAD; else go to DONE.
- DONE: busy = 0, frame_done = 1, then go to IDLE. frame_done stays high until the next accepted start.
- Reset asserted mid-frame: immediate return to reset values. No partial output after release.
- Boundaries: counters wrap to 0 at each line start. No beat is lost or duplicated under any in_valid/out_ready pattern.

Test Plan:
- Forward, LINE_LEN=4, NUM_LINES=1, input 10,20,30,25 -> out 15,27,10,-5; out_last only on -5; frame_done=1 and busy=0 afterwards.
- Inverse, same params, input 15,27,10,-5 -> out 10,20,30,25; out_last on 25; no output during the two L-load beats.
- Extremes, forward, input 0,255,255,0 -> out 127,127,255,-255. Feeding that back through inverse -> 0,255,255,0.
- Backpressure: NUM_LINES=2, random in_valid and out_ready (50%), two forward lines -> 8 outputs, exact order, stable data while stalled; frame_done set only after the 8th beat.
- start pulsed while busy with mode flipped -> ignored; mode stays forward and results are unchanged.
- HRESETn low mid-line (after 3 inputs), then new start with mode=1 -> all outputs 0 during reset; the clean inverse frame is correct; no stale beats.
